// File: rtl/mono_scanout.sv
// 1bpp framebuffer sink and serial scanout for a monochrome panel.
// Words land in an on-chip RAM; a free-running raster reads them back and shifts them out.
module mono_scanout #(
  parameter int WIDTH        = 512,
  parameter int HEIGHT       = 342,
  parameter int H_TOTAL      = 704,
  parameter int H_SYNC_START = 528,
  parameter int H_SYNC_LEN   = 64,
  parameter int V_TOTAL      = 370,
  parameter int V_SYNC_START = 346,
  parameter int V_SYNC_LEN   = 4,
  parameter bit INVERT       = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in_bits,
  input  logic [11:0] in_xaddr,
  input  logic [11:0] in_yaddr,
  input  logic        in_ready,
  input  logic        in_vsync,
  output logic        video_pixel,
  output logic        video_active,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        frame_valid
);

  localparam int WPL   = WIDTH / 16;
  localparam int WORDS = WPL * HEIGHT;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [11:0] W_L      = 12'(WIDTH);
  localparam logic [11:0] HT_L     = 12'(HEIGHT);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] HS_BEGIN = 12'(H_SYNC_START);
  localparam logic [11:0] HS_END   = 12'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [11:0] VS_BEGIN = 12'(V_SYNC_START);
  localparam logic [11:0] VS_END   = 12'(V_SYNC_START + V_SYNC_LEN);

  logic [11:0]   h, v;
  logic          active0, hsync0, vsync0, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [15:0]   rd_data;
  logic          active1, hsync1, vsync1, load1;
  logic [15:0]   shift;
  logic          cur_msb;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? 12'd0 : v + 12'd1;
    end else begin
      h <= h + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_valid <= 1'b0;
    else if (in_vsync) frame_valid <= 1'b1;
  end

  assign active0 = (h < W_L) && (v < HT_L);
  assign hsync0  = (h >= HS_BEGIN) && (h < HS_END);
  assign vsync0  = (v >= VS_BEGIN) && (v < VS_END);
  assign rd_en   = active0 && (h[3:0] == 4'd0);
  assign rd_addr = AW'(v) * AW'(WPL) + AW'(h[11:4]);

  // Range check covers the full address, so underflowed bases such as 12'hFF0 are dropped.
  assign wr_en   = in_ready && (in_xaddr < W_L) && (in_yaddr < HT_L);
  assign wr_addr = AW'(in_yaddr) * AW'(WPL) + AW'(in_xaddr[11:4]);

  logic [15:0] mem [WORDS];

  // NOTE: the framebuffer has no reset so it maps onto block RAM and survives reset_n;
  // the read samples the old word when it collides with a write on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_bits;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active1 <= 1'b0;
      hsync1  <= 1'b0;
      vsync1  <= 1'b0;
      load1   <= 1'b0;
    end else begin
      active1 <= active0;
      hsync1  <= hsync0;
      vsync1  <= vsync0;
      load1   <= rd_en;
    end
  end

  // A freshly read word bypasses the shift register for its first (leftmost) pixel.
  assign cur_msb = load1 ? rd_data[15] : shift[15];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift        <= '0;
      video_pixel  <= 1'b0;
      video_active <= 1'b0;
      video_hsync  <= 1'b0;
      video_vsync  <= 1'b0;
    end else begin
      shift        <= load1 ? {rd_data[14:0], 1'b0} : {shift[14:0], 1'b0};
      video_pixel  <= active1 && frame_valid && (cur_msb ^ INVERT);
      video_active <= active1;
      video_hsync  <= hsync1;
      video_vsync  <= vsync1;
    end
  end

endmodule

// File: tb/tb_mono_scanout.sv
// Directed bench for mono_scanout on a shrunken 32x4 raster (48x8 totals), with normal
// and inverted-polarity instances sharing the same inputs.
module tb_mono_scanout;

  localparam int TW = 32, TH = 4, THT = 48, THSS = 36, THSL = 4;
  localparam int TVT = 8, TVSS = 5, TVSL = 2;
  localparam int FRAME = THT * TVT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in_bits;
  logic [11:0] in_xaddr, in_yaddr;
  logic        in_ready, in_vsync;
  logic        p0, a0, hs0, vs0, fv0;
  logic        p1, a1, hs1, vs1, fv1;

  int checks = 0;
  int errors = 0;
  int e;
  logic [31:0] cap_a [4];
  logic [31:0] cap_b [4];

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) e <= 0;
    else e <= e + 1;
  end

  mono_scanout #(
    .WIDTH(TW), .HEIGHT(TH), .H_TOTAL(THT), .H_SYNC_START(THSS), .H_SYNC_LEN(THSL),
    .V_TOTAL(TVT), .V_SYNC_START(TVSS), .V_SYNC_LEN(TVSL), .INVERT(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_bits(in_bits), .in_xaddr(in_xaddr),
    .in_yaddr(in_yaddr), .in_ready(in_ready), .in_vsync(in_vsync),
    .video_pixel(p0), .video_active(a0), .video_hsync(hs0), .video_vsync(vs0),
    .frame_valid(fv0)
  );

  mono_scanout #(
    .WIDTH(TW), .HEIGHT(TH), .H_TOTAL(THT), .H_SYNC_START(THSS), .H_SYNC_LEN(THSL),
    .V_TOTAL(TVT), .V_SYNC_START(TVSS), .V_SYNC_LEN(TVSL), .INVERT(1'b1)
  ) dut_inv (
    .clk(clk), .reset_n(reset_n), .in_bits(in_bits), .in_xaddr(in_xaddr),
    .in_yaddr(in_yaddr), .in_ready(in_ready), .in_vsync(in_vsync),
    .video_pixel(p1), .video_active(a1), .video_hsync(hs1), .video_vsync(vs1),
    .frame_valid(fv1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the word is written on the following posedge.
  task automatic wr(input logic [11:0] x, input logic [11:0] y, input logic [15:0] d,
                    input logic vs);
    in_xaddr = x;
    in_yaddr = y;
    in_bits  = d;
    in_ready = 1'b1;
    in_vsync = vs;
    @(negedge clk);
    in_ready = 1'b0;
    in_vsync = 1'b0;
  endtask

  // Released at a negedge, hsync must first be seen after edge THSS+2.
  task automatic hs_rise();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hs0) begin
        seen = 1'b1;
        break;
      end
    end
    check("hs_seen", 32'(seen), 32'd1);
    check("hs_rise_clk", e, THSS + 2);
  endtask

  task automatic capture_frame();
    bit   seen = 1'b0;
    logic prev;
    int   k = 0;
    int   blank_ones = 0;
    prev = vs0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (vs0 && !prev) begin
        seen = 1'b1;
        break;
      end
      prev = vs0;
    end
    check("vs_seen", 32'(seen), 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (a0) begin
        if (k < TW * TH) begin
          cap_a[k / TW][31 - (k % TW)] = p0;
          cap_b[k / TW][31 - (k % TW)] = p1;
        end
        k++;
      end else begin
        blank_ones += 32'(p0) + 32'(p1);
      end
    end
    check("act_pix", k, TW * TH);
    check("blank_pix", blank_ones, 0);
  endtask

  task automatic check_line(input int l, input logic [31:0] exp);
    check($sformatf("line%0d", l), cap_a[l], exp);
    check($sformatf("line%0d_inv", l), cap_b[l], ~exp);
  endtask

  // Stops at the negedge where the raster counters sit at (0,0).
  task automatic wait_frame_start();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (e % FRAME == 0) break;
      @(negedge clk);
    end
    check("frame_sync", e % FRAME, 0);
  endtask

  task automatic grab_line(output logic [31:0] la, output logic [31:0] lb);
    int k = 0;
    la = '0;
    lb = '0;
    for (int i = 0; i < 4 * THT; i++) begin
      @(negedge clk);
      if (a0) begin
        la[31 - k] = p0;
        lb[31 - k] = p1;
        k++;
        if (k == TW) break;
      end
    end
    check("grab_cnt", k, TW);
  endtask

  initial begin
    logic [31:0] la, lb;
    int ones, act, hs_hi, hs_up, vs_hi, vs_up;
    logic hs_prev, vs_prev;
    bit seen;

    reset_n  = 1'b0;
    in_bits  = '0;
    in_xaddr = '0;
    in_yaddr = '0;
    in_ready = 1'b0;
    in_vsync = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'({p0, a0, hs0, vs0, fv0, p1, a1, hs1, vs1, fv1}), 32'd0);
    reset_n = 1'b1;
    hs_rise();

    // No source frame yet: pixels stay dark on both polarities, timing still runs.
    wr(12'd0, 12'd0, 16'hFFFF, 1'b0);
    ones = 0; act = 0; hs_hi = 0; hs_up = 0; vs_hi = 0; vs_up = 0;
    hs_prev = hs0;
    vs_prev = vs0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      ones  += 32'(p0) + 32'(p1);
      act   += 32'(a0);
      hs_hi += 32'(hs0);
      vs_hi += 32'(vs0);
      if (hs0 && !hs_prev) hs_up++;
      if (vs0 && !vs_prev) vs_up++;
      hs_prev = hs0;
      vs_prev = vs0;
    end
    check("pre_vs_ones", ones, 0);
    check("pre_vs_fv", 32'({fv0, fv1}), 32'd0);
    check("act_clks", act, TW * TH);
    check("hs_clks", hs_hi, THSL * TVT);
    check("hs_pulses", hs_up, TVT);
    check("vs_clks", vs_hi, TVSL * THT);
    check("vs_pulses", vs_up, 1);

    // in_vsync together with a write: both take effect.
    wr(12'd0, 12'd0, 16'h8001, 1'b1);
    check("fv_set", 32'({fv0, fv1}), 32'd3);
    wr(12'd21, 12'd0, 16'hFFFF, 1'b0);
    wr(12'd0,  12'd1, 16'h0F0F, 1'b0);
    wr(12'd16, 12'd1, 16'h0000, 1'b0);
    wr(12'd0,  12'd2, 16'h3C3C, 1'b0);
    wr(12'd16, 12'd2, 16'hA5A5, 1'b0);
    wr(12'd0,  12'd3, 16'h0000, 1'b0);
    wr(12'd16, 12'd3, 16'hC3C3, 1'b0);
    wr(12'd32,    12'd0, 16'h1234, 1'b0);
    wr(12'd0,     12'd4, 16'h1234, 1'b0);
    wr(12'hFF0,   12'd1, 16'h1234, 1'b0);
    capture_frame();
    check_line(0, 32'h8001_FFFF);
    check_line(1, 32'h0F0F_0000);
    check_line(2, 32'h3C3C_A5A5);
    check_line(3, 32'h0000_C3C3);

    // Overwrite word (0,0) on the very edge it is read.
    wait_frame_start();
    wr(12'd0, 12'd0, 16'h7E00, 1'b0);
    grab_line(la, lb);
    check("coll_old", la, 32'h8001_FFFF);
    check("coll_old_inv", lb, 32'h7FFE_0000);
    wait_frame_start();
    grab_line(la, lb);
    check("coll_new", la, 32'h7E00_FFFF);
    check("coll_new_inv", lb, 32'h81FF_0000);

    // Asynchronous reset mid-line while a pixel is lit.
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (a1 && p1) begin
        seen = 1'b1;
        break;
      end
    end
    check("lit_seen", 32'(seen), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("async_rst", 32'({p0, a0, hs0, vs0, fv0, p1, a1, hs1, vs1, fv1}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    hs_rise();
    check("fv_cleared", 32'({fv0, fv1}), 32'd0);

    // Framebuffer contents survive reset.
    in_vsync = 1'b1;
    @(negedge clk);
    in_vsync = 1'b0;
    capture_frame();
    check_line(0, 32'h7E00_FFFF);
    check_line(2, 32'h3C3C_A5A5);
    check_line(3, 32'h0000_C3C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
